// File: rtl/cpm_pkg.sv
// Shared types and default sizing for the CPM register-bank arbiter.
package cpm_pkg;

  localparam int unsigned CPM_NREQ = 4;
  localparam int unsigned CPM_NREG = 8;
  localparam int unsigned CPM_DW   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } cpm_state_e;

endpackage

// File: rtl/cpm_rr_arb.sv
// Combinational round-robin arbiter: request vector + pointer -> one-hot grant and winner index.
// CPM_ARB_PRIO_EN gives requester 0 fixed top priority; the others keep round-robin.
module cpm_rr_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   win,
  output logic            any,
  output logic            ptr_upd
);

  logic            prio_hit;
  logic [NREQ-1:0] rr_req;

`ifdef CPM_ARB_PRIO_EN
  assign prio_hit = req[0];
  assign rr_req   = req & ~NREQ'(1);
`else
  assign prio_hit = 1'b0;
  assign rr_req   = req;
`endif

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    if (prio_hit) begin
      gnt[0] = 1'b1;
      any    = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!any && rr_req[PW'((32'(ptr) + k) % NREQ)]) begin
          gnt[PW'((32'(ptr) + k) % NREQ)] = 1'b1;
          win = PW'((32'(ptr) + k) % NREQ);
          any = 1'b1;
        end
      end
    end
  end

  // Fixed-priority grants leave the rotation untouched
  assign ptr_upd = any & ~prio_hit;

endmodule

// File: rtl/cpm_reg_bank_arb.sv
// Arbitrates requester writes/clears onto a clearable register bank and sequences bank-wide clear sweeps.
// Optional CPM_ARB_PRIO_EN: requester 0 has fixed top priority.
module cpm_reg_bank_arb
  import cpm_pkg::*;
#(
  parameter  int unsigned NREQ = CPM_NREQ,
  parameter  int unsigned NREG = CPM_NREG,
  parameter  int unsigned DW   = CPM_DW,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NREQ-1:0]    ReqVld,
  output logic [NREQ-1:0]    ReqRdy,
  input  logic [NREQ-1:0]    ReqWr,
  input  logic [NREQ*AW-1:0] ReqAddr,
  input  logic [NREQ*DW-1:0] ReqData,
  input  logic               ClrAll,
  output logic               ClrAllDone,
  output logic [NREG-1:0]    RegEnable,
  output logic [NREG-1:0]    RegClear,
  output logic [DW-1:0]      RegDataIn,
  output logic               AddrErr,
  output logic               Busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  cpm_state_e      state;
  logic [PW-1:0]   ptr;
  logic [AW-1:0]   cnt;
  logic            clr_pend;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   win;
  logic            gnt_any;
  logic            ptr_upd;
  logic            arb_en;
  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            sel_ok;

  cpm_rr_arb #(.NREQ(NREQ)) u_arb (
    .req     (ReqVld),
    .ptr     (ptr),
    .gnt     (gnt),
    .win     (win),
    .any     (gnt_any),
    .ptr_upd (ptr_upd)
  );

  // Grants only while idle with no sweep about to start
  assign arb_en = !Rst && (state == ST_IDLE) && !ClrAll && !clr_pend;
  assign ReqRdy = arb_en ? gnt : '0;

  // Winner's request fields
  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_wr   = ReqWr[i];
        sel_addr = ReqAddr[i*AW +: AW];
        sel_data = ReqData[i*DW +: DW];
      end
    end
  end

  assign sel_ok = (32'(sel_addr) < NREG);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      clr_pend   <= 1'b0;
      ClrAllDone <= 1'b0;
      RegEnable  <= '0;
      RegClear   <= '0;
      RegDataIn  <= '0;
      AddrErr    <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      RegEnable  <= '0;
      RegClear   <= '0;
      AddrErr    <= 1'b0;
      ClrAllDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ClrAll || clr_pend) begin
            state    <= ST_SWEEP;
            cnt      <= '0;
            clr_pend <= 1'b0;
            RegClear <= NREG'(1);
            Busy     <= 1'b1;
          end else if (gnt_any) begin
            if (ptr_upd)
              ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            if (!sel_ok) begin
              AddrErr <= 1'b1;
            end else if (sel_wr) begin
              RegEnable <= NREG'(1) << sel_addr;
              RegDataIn <= sel_data;
            end else begin
              RegClear <= NREG'(1) << sel_addr;
            end
          end
        end
        ST_SWEEP: begin
          if (ClrAll)
            clr_pend <= 1'b1;
          if (cnt == AW'(NREG - 1)) begin
            state      <= ST_DONE;
            ClrAllDone <= 1'b1;
          end else begin
            cnt      <= cnt + AW'(1);
            RegClear <= NREG'(1) << (cnt + AW'(1));
          end
        end
        ST_DONE: begin
          // A clear requested during the sweep restarts straight away
          if (ClrAll || clr_pend) begin
            state    <= ST_SWEEP;
            cnt      <= '0;
            clr_pend <= 1'b0;
            RegClear <= NREG'(1);
            Busy     <= 1'b1;
          end else begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cpm_reg_bank_arb.md
# cpm_reg_bank_arb

- Shares write access to a bank of NREG clearable/enabled configuration registers among NREQ requesters.
- Per-register behaviour of the bank: synchronous clear beats enable.
- Arbitrates with round-robin and drives one-hot per-register Clear/Enable strobes plus a shared data bus.
- Also sequences a bank-wide clear sweep; sits between the CPM config masters and the CPM register bank.

## Interface
- NREQ, 4, number of requesters (2..8)
- NREG, 8, number of registers in the bank (2..64)
- DW, 16, register data width
- AW (localparam), $clog2(NREG), address width
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- ReqVld  in  NREQ  request valid, one bit per requester
- ReqRdy  out  NREQ  grant/ready; a transfer happens when ReqVld[i]&ReqRdy[i]
- ReqWr  in  NREQ  1 = write ReqData, 0 = clear addressed register
- ReqAddr  in  NREQ*AW  requester i at [i*AW +: AW]
- ReqData  in  NREQ*DW  requester i at [i*DW +: DW]
- ClrAll  in  1  single-cycle pulse: start bank-wide clear sweep
- ClrAllDone  out  1  one-cycle pulse when sweep finishes
- RegEnable  out  NREG  one-hot write strobe to bank
- RegClear  out  NREG  one-hot clear strobe to bank
- RegDataIn  out  DW  shared write data to bank
- AddrErr  out  1  one-cycle pulse: accepted request had address >= NREG
- Busy  out  1  high while sweep pending/active

## Operation
- States: IDLE, SWEEP, DONE.
- Reset: IDLE, rr pointer 0, sweep counter 0, clear-pending 0. All outputs 0; ReqRdy 0 in the reset cycle.
- IDLE, ClrAll low, no pending clear:
  - Round-robin search over ReqVld starting at pointer. The first valid requester gets ReqRdy; all other ReqRdy bits are 0.
  - On grant, pointer <= winner+1 mod NREQ.
  - ReqRdy is combinational from ReqVld and pointer only.
- Accepted write: RegEnable[addr]=1, RegDataIn=data next cycle.
- Accepted clear: RegClear[addr]=1 next cycle; RegDataIn holds its previous value.
- Address >= NREG: request is accepted but no strobe is issued; AddrErr pulses next cycle.
- ClrAll high in IDLE, or a pending clear:
  - No grant that cycle; go to SWEEP with counter 0.
  - ClrAll wins over simultaneous requests.
- SWEEP:
  - RegClear[counter]=1, one register per cycle, counter+1.
  - ReqRdy all 0.
  - After counter NREG-1, go to DONE.
- DONE: ClrAllDone=1 for one cycle, return to IDLE; arbitration resumes the next cycle.
- ClrAll during SWEEP/DONE sets clear-pending. Exactly one further sweep follows; multiple ClrAll pulses collapse into one.
- Busy = (state != IDLE) | clear-pending.
- Mid-sweep Rst: sweep aborts, no ClrAllDone, pointer 0.

## Timing
- Cycle t: handshake. Cycle t+1: registered strobe/data. Bank DataOut reflects the write in t+2.
- Throughput: one transfer per cycle in IDLE; back-to-back grants allowed.
- Sweep length: NREG cycles of RegClear, plus 1 cycle DONE. ClrAll at t gives ClrAllDone at t+NREG+1.
- RegEnable/RegClear: at most one bit set per cycle, never both for the same register.
- All outputs except ReqRdy are registered.

## Configuration
- CPM_ARB_PRIO_EN defined:
  - Requester 0 has fixed highest priority whenever ReqVld[0]=1.
  - Requesters 1..NREQ-1 round-robin among themselves; pointer is not updated on requester-0 grants.
- CPM_ARB_PRIO_EN undefined: pure round-robin over all NREQ.

## Structure
- Shared package cpm_pkg:
  - state enum (IDLE/SWEEP/DONE)
  - CPM_NREQ/CPM_NREG/CPM_DW defaults
- Sub-module cpm_rr_arb (NREQ):
  - combinational request vector + pointer -> one-hot grant + winner index
  - priority override under CPM_ARB_PRIO_EN
- The top holds the FSM, sweep counter, and output registers.

## Test plan
All cases use NREQ=4, NREG=8, DW=16.
- Reset then idle: all outputs 0 for 3 cycles; ReqVld=4'b0000 -> ReqRdy=0.
- ReqVld=4'b1111 held, all writes: grants 0,1,2,3,0 on consecutive cycles. Addr i / data 16'hA0+i give RegEnable one-hot 1<<i, RegDataIn=16'hA0+i, one cycle later.
- Req1 clear addr 5 -> RegClear=8'b0010_0000 next cycle. Req2 addr 9 (AW=3 forces aliasing; use NREG=6, addr 7) -> AddrErr pulse, no strobe.
- ClrAll with ReqVld=4'b0001 same cycle -> no grant.
  - RegClear walks 0x01..0x80 over 8 cycles, then ClrAllDone at t+9.
  - Req0 granted at t+10.
- ClrAll again at sweep cycle 3 -> second full sweep immediately after DONE; Busy high throughout.
- Rst at sweep cycle 4 -> RegClear=0 next cycle, no ClrAllDone, Busy=0.
- With CPM_ARB_PRIO_EN: ReqVld=4'b1111 held -> requester 0 granted every cycle.
